// File: rtl/mmio_uart_gpio.sv
// mmio_uart_gpio: memory-mapped GPIO, 8N1 UART with TX/RX FIFOs and runtime
// baud divisor, and a free-running cycle counter.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   mmio_i_addr       byte address, bits [7:2] select the register
//   mmio_i_wmask      byte write enables, non-zero means write
//   mmio_i_wdata      write data
//   mmio_i_ren        read strobe, qualifies the UART_RX pop
//   mmio_o_rdata      registered read data (address of previous cycle)
//   mmio_o_gpio_led   GPIO outputs
//   mmio_i_gpio_btn   asynchronous button inputs
//   mmio_i_gpio_sw    asynchronous switch inputs
//   mmio_i_uart_rx    asynchronous UART receive line
//   mmio_o_uart_tx    UART transmit line, idles high
module mmio_uart_gpio #(
    parameter int unsigned LED_W       = 4,
    parameter int unsigned BTN_W       = 4,
    parameter int unsigned SW_W        = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mmio_i_addr,
    input  logic [3:0]       mmio_i_wmask,
    input  logic [31:0]      mmio_i_wdata,
    input  logic             mmio_i_ren,
    output logic [31:0]      mmio_o_rdata,
    output logic [LED_W-1:0] mmio_o_gpio_led,
    input  logic [BTN_W-1:0] mmio_i_gpio_btn,
    input  logic [SW_W-1:0]  mmio_i_gpio_sw,
    input  logic             mmio_i_uart_rx,
    output logic             mmio_o_uart_tx
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned IN_W = BTN_W + SW_W;

    localparam logic [5:0] A_GPIO_OUT = 6'd0;
    localparam logic [5:0] A_GPIO_IN  = 6'd1;
    localparam logic [5:0] A_UART_TX  = 6'd2;
    localparam logic [5:0] A_UART_RX  = 6'd3;
    localparam logic [5:0] A_STATUS   = 6'd4;
    localparam logic [5:0] A_CLK_DIV  = 6'd5;
    localparam logic [5:0] A_CYCLE    = 6'd6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [LED_W-1:0] r_led;
    logic [IN_W-1:0]  r_in_s1, r_in_s2;
    logic [15:0]      r_div;
    logic [31:0]      r_cycle, r_rdata;
    logic             r_rx_ovr, r_ferr, r_tx_ovf;
    logic [7:0]       r_txq [FIFO_DEPTH];
    logic [7:0]       r_rxq [FIFO_DEPTH];
    logic [PW-1:0]    r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [1:0]       r_tx_st, r_rx_st;
    logic [15:0]      r_tx_cnt, r_rx_cnt;
    logic [2:0]       r_tx_bit, r_rx_bit;
    logic [7:0]       r_tx_sh, r_rx_sh;
    logic             r_tx_line, r_rx_s1, r_rx_s2, r_rx_d;

    logic [5:0]  w_sel;
    logic        w_wr, w_tx_push, w_tx_push_ok, w_tx_pop, w_tx_full, w_tx_empty;
    logic        w_rx_push, w_rx_push_ok, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ferr;
    logic        w_tx_cnt0, w_rx_cnt0, w_rx_fall;
    logic [1:0]  w_tx_st_nxt, w_rx_st_nxt;
    logic [15:0] w_div_m1;
    logic [31:0] w_bmask, w_led_new, w_rdata;
    logic [7:0]  w_status;
    logic        w_unused;

    assign w_sel     = mmio_i_addr[7:2];
    assign w_wr      = |mmio_i_wmask;
    assign w_div_m1  = r_div - 16'd1;
    assign w_bmask   = {{8{mmio_i_wmask[3]}}, {8{mmio_i_wmask[2]}},
                        {8{mmio_i_wmask[1]}}, {8{mmio_i_wmask[0]}}};
    assign w_led_new = (32'(r_led) & ~w_bmask) | (mmio_i_wdata & w_bmask);
    assign w_unused  = ^{mmio_i_addr, mmio_i_wdata};

    // FIFO flags: the extra pointer bit distinguishes full from empty
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands
    assign w_tx_push    = w_wr && (w_sel == A_UART_TX) && mmio_i_wmask[0];
    assign w_tx_push_ok = w_tx_push && (!w_tx_full || w_tx_pop);
    assign w_rx_pop     = mmio_i_ren && (w_sel == A_UART_RX) && !w_rx_empty;
    assign w_rx_push_ok = w_rx_push && (!w_rx_full || w_rx_pop);

    assign w_tx_cnt0 = (r_tx_cnt == 16'd0);
    assign w_rx_cnt0 = (r_rx_cnt == 16'd0);
    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_push = (r_rx_st == S_STOP) && w_rx_cnt0 && r_rx_s2;
    assign w_rx_ferr = (r_rx_st == S_STOP) && w_rx_cnt0 && !r_rx_s2;

    assign w_status = {r_tx_ovf, r_ferr, r_rx_ovr, (r_tx_st != S_IDLE),
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

    // TX next state; STOP chains straight into START when more data waits
    always_comb begin
        w_tx_st_nxt = r_tx_st;
        w_tx_pop    = 1'b0;
        case (r_tx_st)
            S_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_st_nxt = S_START; end
            S_START: if (w_tx_cnt0) w_tx_st_nxt = S_DATA;
            S_DATA:  if (w_tx_cnt0 && (r_tx_bit == 3'd7)) w_tx_st_nxt = S_STOP;
            default: if (w_tx_cnt0) begin
                         if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_st_nxt = S_START; end
                         else w_tx_st_nxt = S_IDLE;
                     end
        endcase
    end

    // RX next state; a high line at the half-bit point rejects a false start
    always_comb begin
        w_rx_st_nxt = r_rx_st;
        case (r_rx_st)
            S_IDLE:  if (w_rx_fall) w_rx_st_nxt = S_START;
            S_START: if (w_rx_cnt0) w_rx_st_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_cnt0 && (r_rx_bit == 3'd7)) w_rx_st_nxt = S_STOP;
            default: if (w_rx_cnt0) w_rx_st_nxt = S_IDLE;
        endcase
    end

    // Read mux, registered below
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            A_GPIO_OUT: w_rdata = 32'(r_led);
            A_GPIO_IN:  w_rdata = 32'(r_in_s2);
            A_UART_TX:  w_rdata = {31'd0, w_tx_full};
            A_UART_RX:  w_rdata = w_rx_empty ? 32'd0 : {1'b1, 23'd0, r_rxq[r_rx_rp[AW-1:0]]};
            A_STATUS:   w_rdata = {24'd0, w_status};
            A_CLK_DIV:  w_rdata = {16'd0, r_div};
            A_CYCLE:    w_rdata = r_cycle;
            default:    w_rdata = 32'd0;
        endcase
    end

    // Register file, synchronisers, sticky flags (a set beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= '0;
            r_div    <= 16'(DEFAULT_DIV);
            r_cycle  <= 32'd0;
            r_rdata  <= 32'd0;
            r_in_s1  <= '0;
            r_in_s2  <= '0;
            r_rx_ovr <= 1'b0;
            r_ferr   <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_rdata <= w_rdata;
            r_in_s1 <= {mmio_i_gpio_btn, mmio_i_gpio_sw};
            r_in_s2 <= r_in_s1;
            if (w_wr && (w_sel == A_GPIO_OUT)) r_led <= w_led_new[LED_W-1:0];
            if (w_wr && (w_sel == A_CLK_DIV))
                r_div <= (mmio_i_wdata[15:0] < 16'd4) ? 16'd4 : mmio_i_wdata[15:0];
            if (w_wr && (w_sel == A_STATUS)) begin
                if (mmio_i_wdata[5]) r_rx_ovr <= 1'b0;
                if (mmio_i_wdata[6]) r_ferr   <= 1'b0;
                if (mmio_i_wdata[7]) r_tx_ovf <= 1'b0;
            end
            if (w_rx_push && !w_rx_push_ok) r_rx_ovr <= 1'b1;
            if (w_rx_ferr)                  r_ferr   <= 1'b1;
            if (w_tx_push && !w_tx_push_ok) r_tx_ovf <= 1'b1;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push_ok) r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)     r_tx_rp <= r_tx_rp + PW'(1);
            if (w_rx_push_ok) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)     r_rx_rp <= r_rx_rp + PW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_tx_push_ok) r_txq[r_tx_wp[AW-1:0]] <= mmio_i_wdata[7:0];
        if (w_rx_push_ok) r_rxq[r_rx_wp[AW-1:0]] <= r_rx_sh;
    end

    // TX datapath; each bit reloads its counter from the live divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st   <= S_IDLE;
            r_tx_cnt  <= 16'd0;
            r_tx_bit  <= 3'd0;
            r_tx_sh   <= 8'd0;
            r_tx_line <= 1'b1;
        end else begin
            r_tx_st <= w_tx_st_nxt;
            if (w_tx_pop) begin
                r_tx_sh   <= r_txq[r_tx_rp[AW-1:0]];
                r_tx_line <= 1'b0;
                r_tx_cnt  <= w_div_m1;
            end else if (r_tx_st != S_IDLE) begin
                if (!w_tx_cnt0) begin
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                end else begin
                    r_tx_cnt <= w_div_m1;
                    if (r_tx_st == S_START) begin
                        r_tx_line <= r_tx_sh[0];
                        r_tx_sh   <= r_tx_sh >> 1;
                        r_tx_bit  <= 3'd0;
                    end else if (r_tx_st == S_DATA) begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_line <= 1'b1;
                        end else begin
                            r_tx_line <= r_tx_sh[0];
                            r_tx_sh   <= r_tx_sh >> 1;
                        end
                    end
                end
            end
        end
    end

    // RX synchroniser and datapath; data bits shift in LSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_st  <= S_IDLE;
            r_rx_cnt <= 16'd0;
            r_rx_bit <= 3'd0;
            r_rx_sh  <= 8'd0;
        end else begin
            r_rx_s1 <= mmio_i_uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_rx_st <= w_rx_st_nxt;
            if (r_rx_st == S_IDLE) begin
                if (w_rx_fall) r_rx_cnt <= (r_div >> 1) - 16'd1;
            end else if (!w_rx_cnt0) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt <= w_div_m1;
                if (r_rx_st == S_START) r_rx_bit <= 3'd0;
                if (r_rx_st == S_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end
        end
    end

    assign mmio_o_rdata    = r_rdata;
    assign mmio_o_gpio_led = r_led;
    assign mmio_o_uart_tx  = r_tx_line;

endmodule

// File: tb/tb_mmio_uart_gpio.sv
// Testbench for mmio_uart_gpio: randomized bus stimulus against a queue-based
// reference model; a read monitor and a TX line decoder check independently.
module tb_mmio_uart_gpio;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;
    logic        ren;
    logic [3:0]  led, btn, sw;
    logic        tx, rx, rx_drv, loop;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    mmio_uart_gpio dut (
        .clk(clk), .rst(rst),
        .mmio_i_addr(addr), .mmio_i_wmask(wmask), .mmio_i_wdata(wdata), .mmio_i_ren(ren),
        .mmio_o_rdata(rdata), .mmio_o_gpio_led(led),
        .mmio_i_gpio_btn(btn), .mmio_i_gpio_sw(sw),
        .mmio_i_uart_rx(rx), .mmio_o_uart_tx(tx)
    );

    typedef struct { string name; logic [31:0] exp; } rd_t;

    int          checks = 0, errors = 0;
    rd_t         rd_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  m_rx_q[$];
    int          start_ticks[$];
    int          tick = 0;
    logic [31:0] tb_cyc;
    bit          rd_pend = 0, tx_abort = 0, mon_busy = 0;
    int          tb_div = 868;
    logic [3:0]  m_led;
    bit          m_ovr = 0, m_ferr = 0, m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected STATUS from the model; TX-side flags are supplied by the caller
    function automatic logic [31:0] st(input bit txf, input bit txe, input bit busy);
        return {24'd0, m_ovf, m_ferr, m_ovr, busy,
                (m_rx_q.size() == DEPTH), (m_rx_q.size() == 0), txe, txf};
    endfunction

    always @(posedge clk) begin
        tick <= tick + 1;
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    // Read monitor: one expected entry per issued read
    always @(posedge clk) begin
        if (rd_pend) begin
            rd_t e;
            #1;
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_underflow: got %h expected none", rdata);
            end else begin
                e = rd_q.pop_front();
                chk(e.name, rdata, e.exp);
            end
        end
    end

    // TX line decoder: samples mid-bit, compares frames with the pushed bytes
    initial begin : tx_mon
        logic [9:0] f;
        bit ab;
        int n;
        forever begin
            @(negedge clk);
            if (tx_abort || rst || tx !== 1'b0) continue;
            mon_busy = 1;
            start_ticks.push_back(tick);
            ab = 0;
            f = '0;
            for (int b = 0; b < 10; b++) begin
                n = (b == 0) ? tb_div / 2 : tb_div;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    if (tx_abort) begin ab = 1; break; end
                end
                if (ab) break;
                f[b] = tx;
            end
            if (!ab) begin
                chk("tx_start_bit", 32'(f[0]), 32'd0);
                chk("tx_stop_bit", 32'(f[9]), 32'd1);
                if (tx_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame: got %h expected none", f[8:1]);
                end else begin
                    chk("tx_byte", 32'(f[8:1]), 32'(tx_exp_q.pop_front()));
                end
            end
            mon_busy = 0;
        end
    end

    task automatic rd(input logic [5:0] idx, input logic [31:0] exp, input string name);
        rd_t e;
        @(negedge clk);
        addr = {24'd0, idx, 2'b00}; ren = 1'b1; rd_pend = 1;
        e.name = name; e.exp = exp; rd_q.push_back(e);
        @(negedge clk);
        addr = 32'd0; ren = 1'b0; rd_pend = 0;
    endtask

    task automatic rd_cyc();
        rd_t e;
        @(negedge clk);
        addr = {24'd0, 6'd6, 2'b00}; ren = 1'b1; rd_pend = 1;
        e.name = "cycle"; e.exp = tb_cyc; rd_q.push_back(e);
        @(negedge clk);
        addr = 32'd0; ren = 1'b0; rd_pend = 0;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = {24'd0, idx, 2'b00}; wdata = d; wmask = m;
        @(negedge clk);
        addr = 32'd0; wdata = 32'd0; wmask = 4'd0;
    endtask

    task automatic push(input logic [7:0] b);
        wr(6'd2, {24'd0, b}, 4'h1);
        tx_exp_q.push_back(b);
        if (loop) begin
            if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
            else m_ovr = 1;
        end
    endtask

    task automatic wait_tx_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (tx_exp_q.size() == 0 && !mon_busy) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d bytes pending expected 0", name, tx_exp_q.size());
        end
        repeat (2 * tb_div) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (tb_div) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * tb_div) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  m;
        logic [7:0]  b;

        rst = 1'b1; addr = 32'd0; wdata = 32'd0; wmask = 4'd0; ren = 1'b0;
        btn = 4'd0; sw = 4'd0; rx_drv = 1'b1; loop = 1'b0; m_led = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Reset values at every offset, plus unmapped ones
        rd(6'd0, 32'd0, "gpio_out_rst");
        rd(6'd1, 32'd0, "gpio_in_rst");
        rd(6'd2, 32'd0, "uart_tx_rst");
        rd(6'd3, 32'd0, "uart_rx_rst");
        rd(6'd4, 32'h06, "status_rst");
        rd(6'd5, 32'd868, "clk_div_rst");
        rd_cyc();
        rd_cyc();
        rd(6'd7, 32'd0, "unmapped_1c");
        rd(6'd63, 32'd0, "unmapped_fc");

        // GPIO outputs with byte masks
        wr(6'd0, 32'hFFFF_FFFF, 4'h1);
        m_led = 4'hF;
        chk("led_pin", 32'(led), 32'(m_led));
        rd(6'd0, 32'(m_led), "gpio_out_rb");
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            wr(6'd0, d, m);
            if (m[0]) m_led = d[3:0];
            chk("led_pin_rand", 32'(led), 32'(m_led));
            rd(6'd0, 32'(m_led), "gpio_out_rand");
        end

        // GPIO inputs through the synchroniser
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin btn = 4'hA; sw = 4'h5; end
            else begin btn = 4'($urandom); sw = 4'($urandom); end
            @(posedge clk);
            @(posedge clk);
            rd(6'd1, {24'd0, btn, sw}, "gpio_in");
        end

        // Divisor clamp and programming
        wr(6'd5, 32'd2, 4'hF);
        rd(6'd5, 32'd4, "clk_div_clamp");
        wr(6'd5, 32'd0, 4'h1);
        rd(6'd5, 32'd4, "clk_div_zero");
        wr(6'd5, 32'd16, 4'hF);
        tb_div = 16;
        rd(6'd5, 32'd16, "clk_div_16");

        // TX: start bit one cycle after the push edge, then framing of 0x55
        @(negedge clk);
        addr = {24'd0, 6'd2, 2'b00}; wdata = 32'h55; wmask = 4'h1;
        tx_exp_q.push_back(8'h55);
        @(negedge clk);
        addr = 32'd0; wdata = 32'd0; wmask = 4'd0;
        chk("tx_idle_at_push", 32'(tx), 32'd1);
        @(negedge clk);
        chk("tx_start_next", 32'(tx), 32'd0);
        wait_tx_done("tx_55_done");
        rd(6'd4, st(0, 1, 0), "status_tx_idle");

        // Back-to-back frames leave no idle gap between start bits
        start_ticks.delete();
        push(8'h00);
        push(8'hFF);
        wait_tx_done("tx_b2b_done");
        chk("tx_b2b_frames", 32'(start_ticks.size()), 32'd2);
        if (start_ticks.size() == 2)
            chk("tx_gapless", 32'(start_ticks[1] - start_ticks[0]), 32'(10 * tb_div));

        // Random bytes with random spacing
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_tx_done("tx_rand_done");

        // Loopback: nine bytes, eight fit in the RX FIFO, one overruns
        loop = 1'b1;
        for (int i = 0; i < 9; i++) push(8'($urandom));
        wait_tx_done("loop_done");
        rd(6'd4, st(0, 1, 0), "status_rx_full_ovr");
        for (int i = 0; i < DEPTH; i++) rd(6'd3, {1'b1, 23'd0, m_rx_q.pop_front()}, "rx_data");
        rd(6'd3, 32'd0, "rx_empty_read");
        rd(6'd4, st(0, 1, 0), "status_ovr_sticky");
        wr(6'd4, 32'h20, 4'h1);
        m_ovr = 0;
        rd(6'd4, st(0, 1, 0), "status_ovr_cleared");
        loop = 1'b0;
        repeat (4) @(negedge clk);

        // Quarter-bit glitch is rejected as a false start
        rx_drv = 1'b0;
        repeat (tb_div / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * tb_div) @(negedge clk);
        rd(6'd4, st(0, 1, 0), "status_glitch");
        rd(6'd3, 32'd0, "rx_after_glitch");

        // Framing error discards the byte
        rx_frame(8'($urandom), 1'b0);
        m_ferr = 1;
        rd(6'd4, st(0, 1, 0), "status_ferr");
        rd(6'd3, 32'd0, "rx_after_ferr");
        wr(6'd4, 32'h40, 4'h1);
        m_ferr = 0;
        rd(6'd4, st(0, 1, 0), "status_ferr_cleared");

        // Directly driven good frames
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            rx_frame(b, 1'b1);
            m_rx_q.push_back(b);
        end
        for (int i = 0; i < 3; i++) rd(6'd3, {1'b1, 23'd0, m_rx_q.pop_front()}, "rx_direct");

        // TX overflow while the transmitter sits in a long start bit
        wr(6'd5, 32'd1000, 4'h3);
        tb_div = 1000;
        push(8'($urandom));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) wr(6'd2, 32'($urandom), 4'h1);
        m_ovf = 1;
        rd(6'd2, 32'd1, "uart_tx_full");
        rd(6'd4, st(1, 0, 1), "status_tx_ovf");

        // Reset mid-frame
        tx_abort = 1;
        repeat (2) @(negedge clk);
        tx_exp_q.delete();
        chk("tx_mid_frame", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tx_high_after_rst", 32'(tx), 32'd1);
        m_led = 4'd0; m_ovf = 0; m_ferr = 0; m_ovr = 0; m_rx_q.delete(); tb_div = 868;
        tx_abort = 0;
        rd(6'd4, 32'h06, "status_after_rst");
        rd(6'd5, 32'd868, "clk_div_after_rst");
        rd(6'd0, 32'(m_led), "gpio_out_after_rst");
        rd_cyc();

        for (int i = 0; i < 20 && rd_q.size() != 0; i++) @(negedge clk);
        if (rd_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rd_drain: got %0d pending expected 0", rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
